// File: rtl/rob_retire_if.sv
// Allocation, completion and retire signal bundle for the reorder buffer.
// The slave side is the ROB; the master side is the rename/execute pipeline.
interface rob_retire_if #(
  parameter int unsigned PTR_W = 4
);
  logic             alloc_valid;
  logic [5:0]       alloc_phys_rd;
  logic [5:0]       alloc_old_phys_rd;
  logic [4:0]       alloc_arch_rd;
  logic             alloc_ready;
  logic [PTR_W-1:0] alloc_idx;
  logic             complete_valid;
  logic [5:0]       complete_phys_reg;
  logic             retire_valid;
  logic [5:0]       retire_phys_reg;
  logic [4:0]       retire_arch_reg;
  logic [5:0]       retire_new_phys_reg;
  logic [PTR_W:0]   rob_count;
  logic             rob_empty;

  modport master (
    output alloc_valid, alloc_phys_rd, alloc_old_phys_rd, alloc_arch_rd,
    output complete_valid, complete_phys_reg,
    input  alloc_ready, alloc_idx,
    input  retire_valid, retire_phys_reg, retire_arch_reg, retire_new_phys_reg,
    input  rob_count, rob_empty
  );

  modport slave (
    input  alloc_valid, alloc_phys_rd, alloc_old_phys_rd, alloc_arch_rd,
    input  complete_valid, complete_phys_reg,
    output alloc_ready, alloc_idx,
    output retire_valid, retire_phys_reg, retire_arch_reg, retire_new_phys_reg,
    output rob_count, rob_empty
  );
endinterface

// File: rtl/rob_retire.sv
// In-order reorder buffer: allocates at tail, marks entries done on writeback,
// retires at most one completed head entry per cycle with a registered pulse.
module rob_retire #(
  parameter int unsigned ROB_DEPTH = 16,
  parameter int unsigned PTR_W     = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  rob_retire_if.slave  bus
);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ROB_DEPTH-1:0] valid_q;
  logic [ROB_DEPTH-1:0] done_q;
  logic [5:0]           phys_q [ROB_DEPTH];
  logic [5:0]           old_q  [ROB_DEPTH];
  logic [4:0]           arch_q [ROB_DEPTH];

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic       retire_valid_q;
  logic [5:0] retire_phys_q;
  logic [4:0] retire_arch_q;
  logic [5:0] retire_new_phys_q;

  logic alloc_ready_c;
  logic alloc_fire_c;
  logic retire_fire_c;

  // Full blocks allocation even when the head retires this cycle.
  assign alloc_ready_c = (count_q < CNT_W'(ROB_DEPTH));
  assign alloc_fire_c  = bus.alloc_valid & alloc_ready_c;
  assign retire_fire_c = valid_q[head_q] & done_q[head_q];

  assign bus.alloc_ready         = alloc_ready_c;
  assign bus.alloc_idx           = tail_q;
  assign bus.rob_count           = count_q;
  assign bus.rob_empty           = (count_q == '0);
  assign bus.retire_valid        = retire_valid_q;
  assign bus.retire_phys_reg     = retire_phys_q;
  assign bus.retire_arch_reg     = retire_arch_q;
  assign bus.retire_new_phys_reg = retire_new_phys_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q           <= '0;
      done_q            <= '0;
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      retire_valid_q    <= 1'b0;
      retire_phys_q     <= '0;
      retire_arch_q     <= '0;
      retire_new_phys_q <= '0;
    end else begin
      retire_valid_q <= retire_fire_c;

      // Writeback matches only entries that were valid before this edge.
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        if (bus.complete_valid && valid_q[i] && (phys_q[i] == bus.complete_phys_reg)) begin
          done_q[i] <= 1'b1;
        end
      end

      if (retire_fire_c) begin
        retire_phys_q     <= old_q[head_q];
        retire_arch_q     <= arch_q[head_q];
        retire_new_phys_q <= phys_q[head_q];
        valid_q[head_q]   <= 1'b0;
        done_q[head_q]    <= 1'b0;
        head_q            <= head_q + PTR_W'(1);
      end

      if (alloc_fire_c) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        phys_q[tail_q]  <= bus.alloc_phys_rd;
        old_q[tail_q]   <= bus.alloc_old_phys_rd;
        arch_q[tail_q]  <= bus.alloc_arch_rd;
        tail_q          <= tail_q + PTR_W'(1);
      end

      case ({alloc_fire_c, retire_fire_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_rob_retire.sv
// Randomized and directed bench for rob_retire against a queue-based model
// of the in-order retire rules.
module tb_rob_retire;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PW    = 4;

  typedef struct {
    logic [5:0] phys;
    logic [5:0] old;
    logic [4:0] arch;
    bit         done;
  } ent_t;

  logic clk;
  logic reset_n;

  rob_retire_if #(.PTR_W(PW)) bus ();

  rob_retire #(.ROB_DEPTH(DEPTH), .PTR_W(PW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  ent_t       q[$];
  int         m_tail;
  bit         m_rv;
  logic [5:0] m_rphys;
  logic [4:0] m_rarch;
  logic [5:0] m_rnew;
  int         n_retired;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the model by one edge using the values presented before it.
  task automatic model_edge(input bit rn, input bit av, input logic [5:0] prd,
                            input logic [5:0] old, input logic [4:0] ard,
                            input bit cv, input logic [5:0] cp);
    bit   do_ret;
    bit   do_alloc;
    ent_t e;
    if (!rn) begin
      q.delete();
      m_tail  = 0;
      m_rv    = 0;
      m_rphys = '0;
      m_rarch = '0;
      m_rnew  = '0;
      return;
    end
    do_ret   = (q.size() > 0) && q[0].done;
    do_alloc = av && (q.size() < DEPTH);
    if (cv) begin
      foreach (q[i]) begin
        if (q[i].phys == cp) begin
          e = q[i];
          e.done = 1;
          q[i] = e;
        end
      end
    end
    m_rv = do_ret;
    if (do_ret) begin
      e = q.pop_front();
      m_rphys = e.old;
      m_rarch = e.arch;
      m_rnew  = e.phys;
      n_retired++;
    end
    if (do_alloc) begin
      e.phys = prd;
      e.old  = old;
      e.arch = ard;
      e.done = 0;
      q.push_back(e);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic compare_all();
    check("retire_valid", 32'(bus.retire_valid), 32'(m_rv));
    check("retire_phys_reg", 32'(bus.retire_phys_reg), 32'(m_rphys));
    check("retire_arch_reg", 32'(bus.retire_arch_reg), 32'(m_rarch));
    check("retire_new_phys_reg", 32'(bus.retire_new_phys_reg), 32'(m_rnew));
    check("rob_count", 32'(bus.rob_count), 32'(q.size()));
    check("rob_empty", 32'(bus.rob_empty), 32'(q.size() == 0));
    check("alloc_ready", 32'(bus.alloc_ready), 32'(q.size() < DEPTH));
    check("alloc_idx", 32'(bus.alloc_idx), 32'(m_tail));
  endtask

  task automatic cycle(input bit rn, input bit av, input logic [5:0] prd,
                       input logic [5:0] old, input logic [4:0] ard,
                       input bit cv, input logic [5:0] cp);
    reset_n               = rn;
    bus.alloc_valid       = av;
    bus.alloc_phys_rd     = prd;
    bus.alloc_old_phys_rd = old;
    bus.alloc_arch_rd     = ard;
    bus.complete_valid    = cv;
    bus.complete_phys_reg = cp;
    @(posedge clk);
    model_edge(rn, av, prd, old, ard, cv, cp);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cycle(1, 0, '0, '0, '0, 0, '0);
  endtask

  task automatic alloc(input logic [5:0] prd, input logic [5:0] old, input logic [4:0] ard);
    cycle(1, 1, prd, old, ard, 0, '0);
  endtask

  task automatic comp(input logic [5:0] cp);
    cycle(1, 0, '0, '0, '0, 1, cp);
  endtask

  task automatic do_reset();
    cycle(0, 0, '0, '0, '0, 0, '0);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    n_retired = 0;
    m_tail    = 0;
    m_rv      = 0;
    m_rphys   = '0;
    m_rarch   = '0;
    m_rnew    = '0;

    do_reset();
    do_reset();
    check("reset_empty", 32'(bus.rob_empty), 32'd1);
    check("reset_ready", 32'(bus.alloc_ready), 32'd1);

    // Single instruction: rd=3, phys 32, old 3.
    alloc(6'd32, 6'd3, 5'd3);
    comp(6'd32);
    check("single_no_early_retire", 32'(bus.retire_valid), 32'd0);
    idle();
    check("single_rv", 32'(bus.retire_valid), 32'd1);
    check("single_old", 32'(bus.retire_phys_reg), 32'd3);
    check("single_arch", 32'(bus.retire_arch_reg), 32'd3);
    check("single_new", 32'(bus.retire_new_phys_reg), 32'd32);
    check("single_empty", 32'(bus.rob_empty), 32'd1);
    idle();
    check("hold_old", 32'(bus.retire_phys_reg), 32'd3);

    // Out-of-order completion retires in program order.
    alloc(6'd33, 6'd10, 5'd1);
    alloc(6'd34, 6'd11, 5'd2);
    comp(6'd34);
    idle();
    check("ooo_b_held", 32'(bus.retire_valid), 32'd0);
    comp(6'd33);
    idle();
    check("ooo_a_first", 32'(bus.retire_new_phys_reg), 32'd33);
    idle();
    check("ooo_b_next", 32'(bus.retire_new_phys_reg), 32'd34);
    check("ooo_b_rv", 32'(bus.retire_valid), 32'd1);
    repeat (2) idle();

    // Fill, overflow attempt, then retire-while-full.
    for (int i = 0; i < 16; i++) alloc(6'(i + 40), 6'(i), 5'(i));
    check("full_count", 32'(bus.rob_count), 32'd16);
    check("full_ready", 32'(bus.alloc_ready), 32'd0);
    alloc(6'd7, 6'd7, 5'd7);
    check("overflow_ignored", 32'(bus.rob_count), 32'd16);
    comp(6'd40);
    cycle(1, 1, 6'd60, 6'd1, 5'd9, 0, '0);
    check("full_retire_count", 32'(bus.rob_count), 32'd15);
    alloc(6'd60, 6'd1, 5'd9);
    check("refill_count", 32'(bus.rob_count), 32'd16);
    for (int i = 1; i < 16; i++) comp(6'(i + 40));
    comp(6'd60);
    repeat (20) idle();
    check("drained", 32'(bus.rob_empty), 32'd1);

    // 40 alloc/complete pairs: pointers wrap without loss.
    n_retired = 0;
    for (int i = 0; i < 40; i++)
      cycle(1, 1, 6'(i % 32), 6'(i % 64), 5'(i % 32), i > 0, 6'((i + 31) % 32));
    comp(6'd7);
    repeat (4) idle();
    check("wrap_retired", 32'(n_retired), 32'd40);

    // Reset with pending work discards everything.
    for (int i = 0; i < 5; i++) alloc(6'(i + 50), 6'(i), 5'(i));
    comp(6'd51);
    comp(6'd52);
    do_reset();
    check("rst_count", 32'(bus.rob_count), 32'd0);
    check("rst_rv", 32'(bus.retire_valid), 32'd0);
    comp(6'd50);
    repeat (3) idle();
    check("rst_no_retire", 32'(bus.retire_valid), 32'd0);
    check("rst_still_empty", 32'(bus.rob_empty), 32'd1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      bit         rn;
      bit         av;
      bit         cv;
      logic [5:0] cp;
      rn = ($urandom_range(0, 199) != 0);
      av = ($urandom_range(0, 99) < 55);
      cv = ($urandom_range(0, 99) < 60);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        cp = q[$urandom_range(0, q.size() - 1)].phys;
      else
        cp = 6'($urandom);
      cycle(rn, av, 6'($urandom), 6'($urandom), 5'($urandom), cv, cp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
